lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_if.sv | 31 +++
 rtl/lsu_align.sv | 44 ++++
 rtl/lsu.sv | 106 ++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: DMType access codes, FSM state encoding, byte-enable
// constants and small decode helpers used by the control path and lane aligner.
package lsu_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RDWAIT, S_RESP, S_ERR} state_e;

  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_e;

  // Unused codes 101-111 fall through to word.
  function automatic size_e dm_size(input logic [2:0] dm);
    case (dm)
      DM_HALF, DM_HALF_U: return SZ_HALF;
      DM_BYTE, DM_BYTE_U: return SZ_BYTE;
      default:            return SZ_WORD;
    endcase
  endfunction

  function automatic logic dm_signed(input logic [2:0] dm);
    return (dm == DM_HALF) || (dm == DM_BYTE);
  endfunction

  // Address offset bits that are meaningful for the access size.
  function automatic logic [1:0] offset_mask(input logic [2:0] dm);
    case (dm_size(dm))
      SZ_HALF: return 2'b10;
      SZ_BYTE: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] dm, input logic [1:0] off);
    return (off & ~offset_mask(dm)) != 2'b00;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// LSU bus bundle: CPU request/response channel plus the word-addressed memory port.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_dmtype;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_dmtype, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_dmtype, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and replicated store data, plus
// lane extraction and sign/zero extension of load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  dmtype,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    be         = BE_WORD;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    half_v     = offset[1] ? rdata[31:16] : rdata[15:0];
    case (offset)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    case (dm_size(dmtype))
      SZ_HALF: begin
        be         = offset[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = dm_signed(dmtype) ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      end
      SZ_BYTE: begin
        be         = BE_BYTE0 << offset;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = dm_signed(dmtype) ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access, IDLE -> ISSUE -> (RDWAIT) -> RESP.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of masking them.
module lsu
  import lsu_pkg::*;
(
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);

  state_e      state;
  logic        we_q;
  logic [2:0]  dm_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        mem_en_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rdata_q;

  logic        trap;
  logic [31:0] addr_in;
  logic [3:0]  be;
  logic [31:0] wdata_lane;
  logic [31:0] rdata_ext;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap    = misaligned(bus.req_dmtype, bus.req_addr[1:0]);
  assign addr_in = bus.req_addr;
`else
  assign trap    = 1'b0;
  assign addr_in = {bus.req_addr[31:2], bus.req_addr[1:0] & offset_mask(bus.req_dmtype)};
`endif

  lsu_align u_align (
    .dmtype     (dm_q),
    .offset     (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (bus.mem_rdata),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      we_q        <= 1'b0;
      dm_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state)
        S_IDLE: if (bus.req_valid) begin
          we_q    <= bus.req_we;
          dm_q    <= bus.req_dmtype;
          addr_q  <= addr_in;
          wdata_q <= bus.req_wdata;
          if (trap) begin
            state       <= S_ERR;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rdata_q     <= '0;
          end else begin
            state    <= S_ISSUE;
            mem_en_q <= 1'b1;
          end
        end
        S_ISSUE: if (bus.mem_ready) begin
          mem_en_q <= 1'b0;
          if (we_q) begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rdata_q     <= '0;
          end else begin
            state <= S_RDWAIT;
          end
        end
        // Read data is only valid in the cycle after the read was accepted.
        S_RDWAIT: begin
          rdata_q     <= rdata_ext;
          rsp_valid_q <= 1'b1;
          state       <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == S_IDLE) && !reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_en_q & we_q;
  assign bus.mem_be    = mem_en_q ? be : '0;
  assign bus.mem_addr  = addr_q[31:2];
  assign bus.mem_wdata = wdata_lane;

endmodule
